// File: rtl/example_data_memory_bus_hs.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module  : example_data_memory_bus_hs                                      |
// | Brief   : valid/ready data-memory bus in front of a synchronous data RAM; |
// |           address decode, wait states, RAM read latency, registered rsp.  |
// | Revision: 1.0 - initial release                                           |
// +---------------------------------------------------------------------------+
module example_data_memory_bus_hs #(
  parameter logic [31:0] DATA_BEGIN    = 32'h8000_0000,
  parameter logic [31:0] DATA_END      = 32'h8000_3FFF,
  parameter int          MEM_WORD_BITS = 12,
  parameter int          WAIT_STATES   = 0,
  parameter int          READ_LATENCY  = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_address,
  input  logic [31:0]              req_write_data,
  input  logic [3:0]               req_byte_enable,
  input  logic                     req_write,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_read_data,
  output logic                     rsp_error,
  output logic [7:0]               err_count,
  output logic [MEM_WORD_BITS-1:0] mem_address,
  output logic                     mem_wren,
  output logic [3:0]               mem_byteena,
  output logic [31:0]              mem_data,
  input  logic [31:0]              mem_q
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_ISSUE = 3'd2,
    S_READ  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [3:0] c_wait_init = 4'(WAIT_STATES);
  localparam logic [3:0] c_read_init = 4'(READ_LATENCY);

  state_t                   r_state;
  state_t                   w_next;
  logic [MEM_WORD_BITS-1:0] r_word;
  logic [31:0]              r_wdata;
  logic [3:0]               r_be;
  logic                     r_write;
  logic [3:0]               r_count;
  logic                     r_req_ready;
  logic                     r_rsp_valid;
  logic [31:0]              r_rsp_data;
  logic                     r_rsp_err;
  logic [7:0]               r_err_count;
  logic                     w_map_err;
  logic                     w_mem_active;
  logic [31:0]              w_masked;

  assign w_map_err = (req_address < DATA_BEGIN) || (req_address > DATA_END) ||
                     (req_address[1:0] != 2'b00);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_map_err)            w_next = S_RESP;
          else if (WAIT_STATES > 0) w_next = S_WAIT;
          else                      w_next = S_ISSUE;
        end
      end
      S_WAIT:  if (r_count == 4'd1) w_next = S_ISSUE;
      S_ISSUE: w_next = r_write ? S_RESP : S_READ;
      S_READ:  if (r_count == 4'd1) w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Disabled byte lanes read back as zero so the response never carries stale RAM bytes.
  for (genvar i = 0; i < 4; i++) begin : g_lane_mask
    assign w_masked[8*i +: 8] = r_be[i] ? mem_q[8*i +: 8] : 8'h00;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_word      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_write     <= 1'b0;
      r_count     <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_req_ready <= (w_next == S_IDLE);
      r_rsp_valid <= (w_next == S_RESP);
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_word     <= req_address[MEM_WORD_BITS+1:2];
            r_wdata    <= req_write_data;
            r_be       <= req_byte_enable;
            r_write    <= req_write;
            r_count    <= c_wait_init;
            r_rsp_data <= '0;
            r_rsp_err  <= w_map_err;
            if (w_map_err && (r_err_count != 8'hFF))
              r_err_count <= r_err_count + 8'd1;
          end
        end
        S_WAIT:  r_count <= r_count - 4'd1;
        S_ISSUE: r_count <= c_read_init;
        S_READ: begin
          r_count <= r_count - 4'd1;
          if (r_count == 4'd1) r_rsp_data <= w_masked;
        end
        default: ;
      endcase
    end
  end

  // RAM side is decoded straight from the state so reset removes the write strobe at once.
  assign w_mem_active = (r_state == S_WAIT) || (r_state == S_ISSUE) || (r_state == S_READ);
  assign mem_address  = w_mem_active ? r_word  : '0;
  assign mem_byteena  = w_mem_active ? r_be    : '0;
  assign mem_data     = w_mem_active ? r_wdata : '0;
  assign mem_wren     = (r_state == S_ISSUE) && r_write;

  assign req_ready     = r_req_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_read_data = r_rsp_data;
  assign rsp_error     = r_rsp_err;
  assign err_count     = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_example_data_memory_bus_hs.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for example_data_memory_bus_hs: one instance at WS=0/RL=1, one at WS=3/RL=2,
// each with its own byte-lane RAM model; a select line steers the shared request bus.
module tb_example_data_memory_bus_hs;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        sel;
  logic        req_valid;
  logic [31:0] req_address;
  logic [31:0] req_write_data;
  logic [3:0]  req_byte_enable;
  logic        req_write;
  logic        rsp_ready;

  logic        req_ready0, rsp_valid0, rsp_error0, mem_wren0;
  logic [31:0] rsp_read_data0, mem_data0, mem_q0;
  logic [7:0]  err_count0;
  logic [11:0] mem_address0;
  logic [3:0]  mem_byteena0;
  logic        req_ready1, rsp_valid1, rsp_error1, mem_wren1;
  logic [31:0] rsp_read_data1, mem_data1, mem_q1;
  logic [7:0]  err_count1;
  logic [11:0] mem_address1;
  logic [3:0]  mem_byteena1;

  logic        obs_req_ready, obs_rsp_valid, obs_rsp_error, obs_mem_wren;
  logic [31:0] obs_rsp_data;
  logic [7:0]  obs_err_count;
  assign obs_req_ready = sel ? req_ready1     : req_ready0;
  assign obs_rsp_valid = sel ? rsp_valid1     : rsp_valid0;
  assign obs_rsp_error = sel ? rsp_error1     : rsp_error0;
  assign obs_mem_wren  = sel ? mem_wren1      : mem_wren0;
  assign obs_rsp_data  = sel ? rsp_read_data1 : rsp_read_data0;
  assign obs_err_count = sel ? err_count1     : err_count0;

  example_data_memory_bus_hs #(.WAIT_STATES(0), .READ_LATENCY(1)) dut0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid & ~sel), .req_ready(req_ready0),
    .req_address(req_address), .req_write_data(req_write_data),
    .req_byte_enable(req_byte_enable), .req_write(req_write),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
    .rsp_read_data(rsp_read_data0), .rsp_error(rsp_error0), .err_count(err_count0),
    .mem_address(mem_address0), .mem_wren(mem_wren0), .mem_byteena(mem_byteena0),
    .mem_data(mem_data0), .mem_q(mem_q0));

  example_data_memory_bus_hs #(.WAIT_STATES(3), .READ_LATENCY(2)) dut1 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid & sel), .req_ready(req_ready1),
    .req_address(req_address), .req_write_data(req_write_data),
    .req_byte_enable(req_byte_enable), .req_write(req_write),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
    .rsp_read_data(rsp_read_data1), .rsp_error(rsp_error1), .err_count(err_count1),
    .mem_address(mem_address1), .mem_wren(mem_wren1), .mem_byteena(mem_byteena1),
    .mem_data(mem_data1), .mem_q(mem_q1));

  // RAM models: preload port shared, one-stage read for dut0, two-stage for dut1.
  logic [31:0] mem0 [0:4095];
  logic [31:0] mem1 [0:4095];
  logic [31:0] p1;
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [31:0] pl_data;

  always @(posedge clock) begin
    if (pl_en) mem0[pl_addr] <= pl_data;
    else if (mem_wren0)
      for (int b = 0; b < 4; b++)
        if (mem_byteena0[b]) mem0[mem_address0][8*b +: 8] <= mem_data0[8*b +: 8];
    mem_q0 <= mem0[mem_address0];
  end

  always @(posedge clock) begin
    if (pl_en) mem1[pl_addr] <= pl_data;
    else if (mem_wren1)
      for (int b = 0; b < 4; b++)
        if (mem_byteena1[b]) mem1[mem_address1][8*b +: 8] <= mem_data1[8*b +: 8];
    p1     <= mem1[mem_address1];
    mem_q1 <= p1;
  end

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic        sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        wr;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_wren;
    logic [7:0]  exp_ec;
    int          hold;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_txn(input string tag, input vec_t v);
    exp_t e;
    exp_t g;
    int   lat;
    int   wren_cnt;
    int   wren_at;
    @(negedge clock);
    sel             = v.sel;
    req_address     = v.addr;
    req_write_data  = v.wdata;
    req_byte_enable = v.be;
    req_write       = v.wr;
    req_valid       = 1'b1;
    chk({tag, "_ready_idle"}, obs_req_ready, 1);
    e.data = v.exp_data; e.err = v.exp_err; e.lat = v.exp_lat;
    sb.push_back(e);
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1; wren_cnt = 0; wren_at = 0;
    while (!obs_rsp_valid && lat < 64) begin
      if (obs_mem_wren) begin wren_cnt++; wren_at = lat; end
      @(posedge clock); #1;
      lat++;
    end
    g = sb.pop_front();
    if (!obs_rsp_valid) begin
      chk({tag, "_rsp_timeout"}, obs_rsp_valid, 1);
      return;
    end
    chk({tag, "_data"}, obs_rsp_data, g.data);
    chk({tag, "_err"}, obs_rsp_error, g.err);
    chk({tag, "_latency"}, lat, g.lat);
    chk({tag, "_wren_count"}, wren_cnt, v.exp_wren);
    chk({tag, "_err_count"}, obs_err_count, v.exp_ec);
    if (v.exp_wren > 0) chk({tag, "_wren_cycle"}, wren_at, g.lat - 1);
    for (int h = 0; h < v.hold; h++) begin
      req_valid   = 1'b1;
      req_address = 32'h8000_0020;
      @(posedge clock); #1;
      chk({tag, "_hold_valid"}, obs_rsp_valid, 1);
      chk({tag, "_hold_data"}, obs_rsp_data, g.data);
      chk({tag, "_hold_ready"}, obs_req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    chk({tag, "_rsp_dropped"}, obs_rsp_valid, 0);
    chk({tag, "_back_idle"}, obs_req_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   wc;
    vec_t v;
    reset = 1'b1; sel = 1'b0; req_valid = 1'b0; req_address = '0; req_write_data = '0;
    req_byte_enable = '0; req_write = 1'b0; rsp_ready = 1'b0;
    pl_en = 1'b1; pl_addr = '0; pl_data = '0;
    // Preload while held in reset.
    @(negedge clock); pl_addr = 12'h000; pl_data = 32'hDEAD_BEEF;
    @(negedge clock); pl_addr = 12'h001; pl_data = 32'hCAFE_F00D;
    @(negedge clock); pl_addr = 12'h004; pl_data = 32'h1111_1111;
    @(negedge clock); pl_addr = 12'hFFF; pl_data = 32'h0000_0000;
    @(negedge clock); pl_en = 1'b0;
    chk("rst_req_ready", req_ready0, 1);
    chk("rst_rsp_valid", rsp_valid0, 0);
    chk("rst_rsp_data", rsp_read_data0, 0);
    chk("rst_rsp_error", rsp_error0, 0);
    chk("rst_err_count", err_count0, 0);
    chk("rst_mem_wren", mem_wren0, 0);
    chk("rst_mem_address", mem_address0, 0);
    chk("rst_mem_byteena", mem_byteena0, 0);
    chk("rst_mem_data", mem_data0, 0);
    reset = 1'b0;

    //         sel   addr           wdata          be       wr    exp_data       err   lat wr ec     hold
    vecs[0]  = '{1'b0, 32'h8000_0000, 32'h0,         4'hF,    1'b0, 32'hDEAD_BEEF, 1'b0, 3, 0, 8'd0, 0};
    vecs[1]  = '{1'b0, 32'h8000_3FFC, 32'h1234_5678, 4'hF,    1'b1, 32'h0,         1'b0, 2, 1, 8'd0, 0};
    vecs[2]  = '{1'b0, 32'h8000_3FFC, 32'h0,         4'b0011, 1'b0, 32'h0000_5678, 1'b0, 3, 0, 8'd0, 0};
    vecs[3]  = '{1'b0, 32'h8000_4000, 32'h5555_5555, 4'hF,    1'b1, 32'h0,         1'b1, 1, 0, 8'd1, 0};
    vecs[4]  = '{1'b0, 32'h8000_0002, 32'h0,         4'hF,    1'b0, 32'h0,         1'b1, 1, 0, 8'd2, 0};
    vecs[5]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'hF,    1'b0, 32'h0,         1'b1, 1, 0, 8'd3, 0};
    vecs[6]  = '{1'b0, 32'h8000_0000, 32'h0,         4'b1100, 1'b0, 32'hDEAD_0000, 1'b0, 3, 0, 8'd3, 0};
    vecs[7]  = '{1'b0, 32'h8000_3FFC, 32'hAB00_0000, 4'b1000, 1'b1, 32'h0,         1'b0, 2, 1, 8'd3, 0};
    vecs[8]  = '{1'b0, 32'h8000_3FFC, 32'h0,         4'hF,    1'b0, 32'hAB34_5678, 1'b0, 3, 0, 8'd3, 0};
    vecs[9]  = '{1'b1, 32'h8000_0004, 32'h0,         4'hF,    1'b0, 32'hCAFE_F00D, 1'b0, 7, 0, 8'd0, 5};
    vecs[10] = '{1'b1, 32'h8000_0008, 32'h0BAD_CAFE, 4'hF,    1'b1, 32'h0,         1'b0, 5, 1, 8'd0, 0};
    vecs[11] = '{1'b1, 32'h8000_0008, 32'h0,         4'hF,    1'b0, 32'h0BAD_CAFE, 1'b0, 7, 0, 8'd0, 0};
    for (int i = 0; i < 12; i++) do_txn($sformatf("v%0d", i), vecs[i]);

    // Reset while a store sits in its wait states.
    @(negedge clock);
    sel = 1'b1; req_address = 32'h8000_0010; req_write_data = 32'hAAAA_AAAA;
    req_byte_enable = 4'hF; req_write = 1'b1; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("rst_mid_busy", obs_req_ready, 0);
    wc = 0;
    @(posedge clock); #1;
    if (obs_mem_wren) wc++;
    #3 reset = 1'b1;
    #1;
    chk("rst_mid_wren_async", obs_mem_wren, 0);
    @(posedge clock); #1;
    chk("rst_mid_ready", obs_req_ready, 1);
    chk("rst_mid_rsp_valid", obs_rsp_valid, 0);
    @(negedge clock); reset = 1'b0;
    repeat (8) begin
      @(posedge clock); #1;
      if (obs_mem_wren) wc++;
      if (obs_rsp_valid) wc++;
    end
    chk("rst_mid_no_activity", wc, 0);
    v = '{1'b1, 32'h8000_0010, 32'h0, 4'hF, 1'b0, 32'h1111_1111, 1'b0, 7, 0, 8'd0, 0};
    do_txn("rst_discard", v);

    // Error counter saturation.
    sel = 1'b0;
    chk("sat_start", err_count0, 0);
    for (int i = 1; i <= 256; i++) begin
      v = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 1'b0, 32'h0, 1'b1, 1, 0,
            (i > 255) ? 8'hFF : 8'(i), 0};
      do_txn($sformatf("sat%0d", i), v);
    end
    chk("sat_final", err_count0, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
